neighbourhood_window: RTL and testbench

NEIGHBOURHOOD_WINDOW -- requirements
Module: neighbourhood_window

---
 rtl/neighbourhood_window.sv | 199 +++++++++++++++++++
 tb/tb_neighbourhood_window.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neighbourhood_window.sv
// neighbourhood_window
//   Raster-scan window generator for a connected-component labeler. Each
//   accepted pixel is presented one cycle later together with its
//   coordinates and the labels of its already-labelled neighbours:
//       A B C      A=(x-1,y-1)  B=(x,y-1)  C=(x+1,y-1)
//       D *        D=(x-1,y)
//   The labeler answers on label_in the cycle after en; that label is stored
//   in a one-row line buffer and also used as the next pixel's D.
//
//   Build option:
//     CCL_EIGHT_CONN_EN  defined   -> 8-connectivity, A and C are driven.
//                        undefined -> 4-connectivity, A and C are always 0.
//
//   Handshake: a pixel is transferred on a rising edge where
//     pix_valid & pix_ready (and, in IDLE, pix_sof) are high.
//     pix_ready is low in FLUSH and while reset_n is low. en is a strobe
//     with no back-pressure; label_in must be valid the cycle after en.
//
//   Ports
//     clk, reset_n          clock, asynchronous active-low reset
//     pix_valid/sof/data    pixel input stream, pix_sof marks pixel (0,0)
//     pix_ready             pixel accepted this cycle when valid
//     label_in              labeler result for the pixel strobed last cycle
//     en                    window valid strobe
//     data, A, B, C, D      presented pixel and neighbour labels
//     x, y                  coordinates of the presented pixel
//     frame_done            one-cycle pulse after the frame's last label
//     dbg_state             current FSM state (IDLE=0, RUN=1, FLUSH=2)
//
//   Limitation: with IMG_WIDTH=2 the label of (1,y-1) arrives after the
//   window of (0,y) is registered, so C of column 0 is not meaningful there.

`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module neighbourhood_window #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  input  logic [`WORD_SIZE-1:0] pix_data,
  output logic                  pix_ready,
  input  logic [`WORD_SIZE-1:0] label_in,
  output logic                  en,
  output logic [`WORD_SIZE-1:0] data,
  output logic [`WORD_SIZE-1:0] A,
  output logic [`WORD_SIZE-1:0] B,
  output logic [`WORD_SIZE-1:0] C,
  output logic [`WORD_SIZE-1:0] D,
  output logic [31:0]           x,
  output logic [31:0]           y,
  output logic                  frame_done,
  output logic [1:0]            dbg_state
);

  localparam int          XW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [31:0] X_LAST = 32'(IMG_WIDTH - 1);
  localparam logic [31:0] Y_LAST = 32'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic        accept;
  logic [31:0] nxt_x, nxt_y;   // position the next non-sof pixel takes
  logic [31:0] cur_x, cur_y;   // position of the pixel offered this cycle
  logic        is_last;

  // en pipeline: cap_v marks the cycle label_in is valid, cap_col its column
  logic          en_last, cap_v, cap_last;
  logic [XW-1:0] cap_col, rd_col;

  logic [`WORD_SIZE-1:0] line_buf [IMG_WIDTH];
  logic [`WORD_SIZE-1:0] last_label;

  // w1/w2: previous-row labels of columns x and x+1 of the presented pixel,
  // captured before the current row could overwrite them. Shifting these
  // along the row keeps A and B immune to gaps between pixels.
  logic [`WORD_SIZE-1:0] w1, w2;
  logic [`WORD_SIZE-1:0] col0_lbl, rd_lbl, new_w1, new_w2;
`ifdef CCL_EIGHT_CONN_EN
  logic [`WORD_SIZE-1:0] new_w0;
`endif

  assign dbg_state = state_q;
  assign cur_x     = pix_sof ? '0 : nxt_x;
  assign cur_y     = pix_sof ? '0 : nxt_y;
  assign is_last   = (cur_x == X_LAST) && (cur_y == Y_LAST);
  assign rd_col    = (cur_x == X_LAST) ? '0 : XW'(cur_x + 32'd1);

  // A label being written this cycle is forwarded so that narrow images still
  // read the previous row's final value.
  assign col0_lbl = (cap_v && cap_col == '0)    ? label_in : line_buf[0];
  assign rd_lbl   = (cap_v && cap_col == rd_col) ? label_in : line_buf[rd_col];

  assign new_w1 = (cur_x == '0) ? col0_lbl : w2;
  assign new_w2 = rd_lbl;
`ifdef CCL_EIGHT_CONN_EN
  assign new_w0 = (cur_x == '0) ? '0 : w1;
`endif

  // FSM next state and handshake
  always_comb begin
    state_d   = state_q;
    pix_ready = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        pix_ready = reset_n;
        accept    = reset_n & pix_valid & pix_sof;
        if (accept) state_d = RUN;
      end
      RUN: begin
        pix_ready = reset_n;
        accept    = reset_n & pix_valid;
        if (accept && is_last) state_d = FLUSH;
      end
      FLUSH: begin
        if (cap_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // D follows label_in directly when the left neighbour was strobed in the
  // immediately preceding cycle; otherwise the stored copy is used.
  always_comb begin
    D = '0;
    if (x != '0) D = cap_v ? label_in : last_label;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      nxt_x      <= '0;
      nxt_y      <= '0;
      x          <= '0;
      y          <= '0;
      en         <= 1'b0;
      en_last    <= 1'b0;
      cap_v      <= 1'b0;
      cap_last   <= 1'b0;
      cap_col    <= '0;
      frame_done <= 1'b0;
      last_label <= '0;
      data       <= '0;
      A          <= '0;
      B          <= '0;
      C          <= '0;
      w1         <= '0;
      w2         <= '0;
    end else begin
      state_q    <= state_d;
      en         <= accept;
      en_last    <= accept & is_last;
      cap_v      <= en;
      cap_last   <= en_last;
      cap_col    <= XW'(x);
      frame_done <= (state_q == FLUSH) & cap_last;
      if (cap_v) last_label <= label_in;
      if (accept) begin
        x    <= cur_x;
        y    <= cur_y;
        data <= pix_data;
        w1   <= new_w1;
        w2   <= new_w2;
        if (cur_x == X_LAST) begin
          nxt_x <= '0;
          nxt_y <= cur_y + 32'd1;
        end else begin
          nxt_x <= cur_x + 32'd1;
          nxt_y <= cur_y;
        end
        B <= (cur_y == '0) ? '0 : new_w1;
`ifdef CCL_EIGHT_CONN_EN
        A <= (cur_y == '0 || cur_x == '0)    ? '0 : new_w0;
        C <= (cur_y == '0 || cur_x == X_LAST) ? '0 : new_w2;
`else
        A <= '0;
        C <= '0;
`endif
      end
    end
  end

  // Line buffer holds no reset; row-0 and edge masking hide stale content.
  always_ff @(posedge clk) begin
    if (cap_v) line_buf[cap_col] <= label_in;
  end

endmodule

// File: tb/tb_neighbourhood_window.sv
// tb_neighbourhood_window
//   Self-checking bench for neighbourhood_window (IMG_WIDTH=4, IMG_HEIGHT=3).
//   The bench plays the labeler: each presented pixel gets a label chosen by
//   the bench, returned on label_in the following cycle and recorded in a
//   label map from which the expected neighbourhood is derived.

`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module tb_neighbourhood_window;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int WS = `WORD_SIZE;
  localparam int PW = 16 + WS;
`ifdef CCL_EIGHT_CONN_EN
  localparam bit EIGHT = 1'b1;
`else
  localparam bit EIGHT = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          reset_n;
  logic          pix_valid, pix_sof;
  logic [WS-1:0] pix_data;
  logic          pix_ready;
  logic [WS-1:0] label_in;
  logic          en;
  logic [WS-1:0] data, A, B, C, D;
  logic [31:0]   x, y;
  logic          frame_done;
  logic [1:0]    dbg_state;

  neighbourhood_window #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .label_in   (label_in),
    .en         (en),
    .data       (data),
    .A          (A),
    .B          (B),
    .C          (C),
    .D          (D),
    .x          (x),
    .y          (y),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int fd_count = 0;

  bit m_run = 0;          // inside a frame
  int m_pos = 0;          // raster index of next pixel
  int m_busy_until = -1;  // last cycle with pix_ready low after a frame end
  int m_done_at = -1;     // cycle in which frame_done is due
  bit exp_ready = 0;
  bit en_exp = 0;
  bit last_acc = 0;
  bit pend = 0;
  logic [WS-1:0] pend_lbl = '0;
  logic [WS-1:0] label_map [H][W];

  logic [PW-1:0] exp_q[$];   // {x[7:0], y[7:0], data}
  logic [WS-1:0] lbl_q[$];

  typedef struct packed {
    logic [7:0]    ox, oy;
    logic [WS-1:0] oa, ob, oc, od;
  } obs_t;
  obs_t obs_q[$];
  bit   rec = 0;

  typedef struct {
    int gap;
    bit sof;
    int d, lbl, ex, ey, ea, eb, ec, ed;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic set_vec(input int i, input int gap, input bit sof, input int d, input int lbl,
                         input int ex, input int ey, input int ea, input int eb, input int ec,
                         input int ed);
    tbl[i].gap = gap; tbl[i].sof = sof; tbl[i].d = d; tbl[i].lbl = lbl;
    tbl[i].ex = ex; tbl[i].ey = ey; tbl[i].ea = ea; tbl[i].eb = eb; tbl[i].ec = ec; tbl[i].ed = ed;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input bit v, input bit s, input logic [WS-1:0] d,
                       input logic [WS-1:0] lbl, input bit rst);
    logic [PW-1:0] item;
    logic [WS-1:0] lab, ea, eb, ec, ed;
    int px, py;
    bit acc;
    @(posedge clk);
    #1;
    cyc++;
    reset_n   = ~rst;
    pix_valid = v;
    pix_sof   = s;
    pix_data  = d;
    label_in  = pend ? pend_lbl : WS'($urandom);
    pend      = 0;
    acc       = 0;
    if (rst) begin
      m_run = 0; m_pos = 0; m_busy_until = -1; m_done_at = -1;
      exp_q.delete(); lbl_q.delete();
      exp_ready = 0; en_exp = 0; last_acc = 0;
    end else begin
      exp_ready = (cyc > m_busy_until);
      en_exp    = last_acc;
      acc       = v && exp_ready && (m_run || s);
      if (acc) begin
        if (s) m_pos = 0;
        exp_q.push_back({8'(m_pos % W), 8'(m_pos / W), d});
        lbl_q.push_back(lbl);
        if (m_pos == W * H - 1) begin
          m_run = 0;
          m_busy_until = cyc + 2;
          m_done_at = cyc + 3;
        end else begin
          m_run = 1;
          m_pos++;
        end
      end
      last_acc = acc;
    end

    @(negedge clk);
    check("pix_ready", 32'(pix_ready), 32'(exp_ready));
    check("en", 32'(en), 32'(en_exp));
    check("frame_done", 32'(frame_done), 32'(cyc == m_done_at));
    if (frame_done) fd_count++;
    if (en_exp) begin
      item = exp_q.pop_front();
      lab  = lbl_q.pop_front();
      px = int'(item[PW-1 -: 8]);
      py = int'(item[PW-9 -: 8]);
      ea = '0; eb = '0; ec = '0; ed = '0;
      if (px > 0) ed = label_map[py][px-1];
      if (py > 0) eb = label_map[py-1][px];
      if (EIGHT && py > 0 && px > 0) ea = label_map[py-1][px-1];
      if (EIGHT && py > 0 && px < W - 1) ec = label_map[py-1][px+1];
      check("x", x, 32'(px));
      check("y", y, 32'(py));
      check("data", 32'(data), 32'(item[WS-1:0]));
      check("A", 32'(A), 32'(ea));
      check("B", 32'(B), 32'(eb));
      check("C", 32'(C), 32'(ec));
      check("D", 32'(D), 32'(ed));
      label_map[py][px] = lab;
      pend = 1;
      pend_lbl = lab;
      if (rec) obs_q.push_back('{x[7:0], y[7:0], A, B, C, D});
    end
  endtask

  // ---------------- test ----------------
  initial begin
    obs_t o;
    int   fd0;
    bit   v, s, r;
    reset_n = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0; label_in = '0;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) label_map[i][j] = '0;

    // reset state
    cycle(0, 0, '0, '0, 1);
    cycle(1, 1, 8'd1, '0, 1);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_data", 32'(data), 0);
    check("rst_A", 32'(A), 0);
    check("rst_B", 32'(B), 0);
    check("rst_C", 32'(C), 0);
    check("rst_D", 32'(D), 0);
    check("rst_state", 32'(dbg_state), 0);

    // directed frame: {gap, sof, data, label, x, y, A, B, C, D}
    set_vec(0,  0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    set_vec(1,  0, 0, 1, 1, 1, 0, 0, 0, 0, 1);
    set_vec(2,  0, 0, 0, 0, 2, 0, 0, 0, 0, 1);
    set_vec(3,  0, 0, 1, 2, 3, 0, 0, 0, 0, 0);
    set_vec(4,  0, 0, 1, 1, 0, 1, 0, 1, 1, 0);
    set_vec(5,  0, 0, 1, 4, 1, 1, 1, 1, 0, 1);
    set_vec(6,  3, 0, 1, 5, 2, 1, 1, 0, 2, 4);
    set_vec(7,  0, 0, 1, 3, 3, 1, 0, 2, 0, 5);
    set_vec(8,  1, 0, 1, 6, 0, 2, 0, 1, 4, 0);
    set_vec(9,  0, 0, 0, 0, 1, 2, 1, 4, 5, 6);
    set_vec(10, 0, 0, 1, 7, 2, 2, 4, 5, 3, 0);
    set_vec(11, 0, 0, 1, 8, 3, 2, 5, 3, 0, 7);

    rec = 1;
    fd0 = fd_count;
    for (int i = 0; i < 12; i++) begin
      repeat (tbl[i].gap) cycle(0, 0, '0, '0, 0);
      cycle(1, tbl[i].sof, WS'(tbl[i].d), WS'(tbl[i].lbl), 0);
    end
    repeat (4) cycle(0, 0, '0, '0, 0);
    rec = 0;
    check("frame_done_pulses", 32'(fd_count - fd0), 1);
    check("ready_after_frame", 32'(pix_ready), 1);
    check("obs_count", 32'(obs_q.size()), 12);
    for (int i = 0; i < 12; i++) begin
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        check("tbl_x", 32'(o.ox), 32'(tbl[i].ex));
        check("tbl_y", 32'(o.oy), 32'(tbl[i].ey));
        check("tbl_A", 32'(o.oa), EIGHT ? 32'(tbl[i].ea) : 32'd0);
        check("tbl_B", 32'(o.ob), 32'(tbl[i].eb));
        check("tbl_C", 32'(o.oc), EIGHT ? 32'(tbl[i].ec) : 32'd0);
        check("tbl_D", 32'(o.od), 32'(tbl[i].ed));
      end
    end

    // reset in the middle of a frame while (2,1) is offered
    cycle(1, 1, 8'd1, 8'd3, 0);
    repeat (5) cycle(1, 0, 8'd1, 8'd3, 0);
    cycle(1, 0, 8'd1, 8'd3, 1);
    check("midrst_en", 32'(en), 0);
    check("midrst_ready", 32'(pix_ready), 0);
    check("midrst_x", x, 0);
    cycle(0, 0, '0, '0, 0);
    check("release_en", 32'(en), 0);
    check("release_ready", 32'(pix_ready), 1);
    cycle(1, 0, 8'd1, 8'd2, 0);
    cycle(0, 0, '0, '0, 0);
    check("nonsof_dropped", 32'(en), 0);
    cycle(1, 1, 8'd1, 8'd2, 0);
    cycle(0, 0, '0, '0, 0);
    check("sof_en", 32'(en), 1);
    check("sof_x", x, 0);
    check("sof_y", y, 0);

    // randomized traffic: gaps, restarts, occasional resets
    for (int i = 0; i < 800; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = m_run ? ($urandom_range(0, 40) == 0) : ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 399) == 0);
      cycle(v, s, WS'($urandom_range(0, 1)), WS'($urandom_range(0, 15)), r);
    end
    repeat (5) cycle(0, 0, '0, '0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
